// File: rtl/bank_rd_mux_if.sv
// Read-return bus between the requester/bank array side and bank_rd_mux.
// master : drives read requests, flush and the flattened bank read data
// slave  : the mux; returns registered read data, valid, pending count, busy
// Optional BANK_RD_MUX_ERR_EN adds o_sel_err / o_err_seen.
interface bank_rd_mux_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 4
);
    logic                            i_rd_en;
    logic [SEL_WIDTH-1:0]            i_bank_sel;
    logic                            i_flush;
    logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_data;
    logic [DATA_WIDTH-1:0]           o_rd_data;
    logic                            o_rd_valid;
    logic [CNT_WIDTH-1:0]            o_pending;
    logic                            o_busy;
`ifdef BANK_RD_MUX_ERR_EN
    logic                            o_sel_err;
    logic                            o_err_seen;
`endif

    modport master (
        output i_rd_en, i_bank_sel, i_flush, i_bank_data,
        input  o_rd_data, o_rd_valid, o_pending, o_busy
`ifdef BANK_RD_MUX_ERR_EN
        , input o_sel_err, o_err_seen
`endif
    );

    modport slave (
        input  i_rd_en, i_bank_sel, i_flush, i_bank_data,
        output o_rd_data, o_rd_valid, o_pending, o_busy
`ifdef BANK_RD_MUX_ERR_EN
        , output o_sel_err, o_err_seen
`endif
    );
endinterface

// File: rtl/bank_rd_mux.sv
// Latency-aware read-return multiplexer for the multi-bank memory.
// Each request's bank select travels through a READ_LATENCY-deep valid/sel
// pipeline; when it reaches the tail the addressed bank's data is registered
// onto the single read channel.
// Ports: i_clk, i_rst_n (async active-low), bus (bank_rd_mux_if.slave).
// Optional macro BANK_RD_MUX_ERR_EN: adds o_sel_err pulse and sticky o_err_seen
// flagging out-of-range bank selects.
module bank_rd_mux #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned SEL_WIDTH    = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input logic         i_clk,
    input logic         i_rst_n,
    bank_rd_mux_if.slave bus
);
    logic [READ_LATENCY-1:0] vld_q;
    logic [SEL_WIDTH-1:0]    sel_q [READ_LATENCY];

    logic                    capture;
    logic                    tail_vld;
    logic [SEL_WIDTH-1:0]    tail_sel;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    sel_oor;

    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;
    logic [CNT_WIDTH-1:0]    pending_q;

    // Flush wins over a same-cycle request.
    assign capture  = bus.i_rd_en & ~bus.i_flush;
    assign tail_vld = vld_q[READ_LATENCY-1];
    assign tail_sel = sel_q[READ_LATENCY-1];

    // Bank steering; unmatched codes give zero data instead of X.
    always_comb begin
        mux_data = '0;
        sel_oor  = 1'b1;
        for (int k = 0; k < int'(NUM_BANKS); k++) begin
            if (tail_sel == SEL_WIDTH'(k)) begin
                mux_data = bus.i_bank_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_oor  = 1'b0;
            end
        end
    end

    // Request tracking pipeline, no stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) sel_q[i] <= '0;
        end else begin
            vld_q[0] <= capture;
            sel_q[0] <= capture ? bus.i_bank_sel : '0;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                sel_q[i] <= sel_q[i-1];
            end
            if (bus.i_flush) vld_q <= '0;
        end
    end

    // Registered return channel and in-flight counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            pending_q  <= '0;
        end else if (bus.i_flush) begin
            rd_valid_q <= 1'b0;
            pending_q  <= '0;
        end else begin
            rd_valid_q <= tail_vld;
            if (tail_vld) rd_data_q <= mux_data;
            case ({capture, tail_vld})
                2'b10:   pending_q <= pending_q + CNT_WIDTH'(1);
                2'b01:   pending_q <= pending_q - CNT_WIDTH'(1);
                default: pending_q <= pending_q;
            endcase
        end
    end

    assign bus.o_rd_data  = rd_data_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_pending  = pending_q;
    assign bus.o_busy     = |pending_q;

`ifdef BANK_RD_MUX_ERR_EN
    logic sel_err_q;
    logic err_seen_q;

    // Error pulse aligned with o_rd_valid; sticky flag cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_err_q  <= 1'b0;
            err_seen_q <= 1'b0;
        end else if (bus.i_flush) begin
            sel_err_q  <= 1'b0;
        end else begin
            sel_err_q  <= tail_vld & sel_oor;
            err_seen_q <= err_seen_q | (tail_vld & sel_oor);
        end
    end

    assign bus.o_sel_err  = sel_err_q;
    assign bus.o_err_seen = err_seen_q;
`endif
endmodule

// File: tb/tb_bank_rd_mux.sv
module tb_bank_rd_mux;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  sel   = 2'd0;
    logic        flush = 1'b0;
    logic [31:0] bank_data = 32'h0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [3:0] b2b_sel [9] = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       b2b_v   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] b2b_d   [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h43, 8'h10, 8'h21, 8'h32, 8'h32};
    logic [3:0] b2b_p   [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};

    always #5 clk = ~clk;

    bank_rd_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .CNT_WIDTH(4)) if1 ();
    bank_rd_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .CNT_WIDTH(4)) if2 ();
    bank_rd_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .CNT_WIDTH(4)) if3 ();
    bank_rd_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .CNT_WIDTH(4)) if4 ();
    bank_rd_mux_if #(.DATA_WIDTH(8), .NUM_BANKS(3), .SEL_WIDTH(2), .CNT_WIDTH(4)) if5 ();

    assign if1.i_rd_en = rd_en; assign if1.i_bank_sel = sel; assign if1.i_flush = flush; assign if1.i_bank_data = bank_data;
    assign if2.i_rd_en = rd_en; assign if2.i_bank_sel = sel; assign if2.i_flush = flush; assign if2.i_bank_data = bank_data;
    assign if3.i_rd_en = rd_en; assign if3.i_bank_sel = sel; assign if3.i_flush = flush; assign if3.i_bank_data = bank_data;
    assign if4.i_rd_en = rd_en; assign if4.i_bank_sel = sel; assign if4.i_flush = flush; assign if4.i_bank_data = bank_data;
    assign if5.i_rd_en = rd_en; assign if5.i_bank_sel = sel; assign if5.i_flush = flush; assign if5.i_bank_data = bank_data[23:0];

    bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .READ_LATENCY(1), .CNT_WIDTH(4))
        u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
    bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .READ_LATENCY(2), .CNT_WIDTH(4))
        u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
    bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .READ_LATENCY(3), .CNT_WIDTH(4))
        u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
    bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_WIDTH(2), .READ_LATENCY(4), .CNT_WIDTH(4))
        u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
    bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(3), .SEL_WIDTH(2), .READ_LATENCY(1), .CNT_WIDTH(4))
        u5 (.i_clk(clk), .i_rst_n(rst_n), .bus(if5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held for 3 cycles, then 10 idle cycles (READ_LATENCY=1)
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", 32'(if1.o_rd_valid), 32'h0);
            chk("rst_data", 32'(if1.o_rd_data), 32'h0);
            chk("rst_pending", 32'(if1.o_pending), 32'h0);
            chk("rst_busy", 32'(if1.o_busy), 32'h0);
`ifdef BANK_RD_MUX_ERR_EN
            chk("rst_sel_err", 32'(if5.o_sel_err), 32'h0);
            chk("rst_err_seen", 32'(if5.o_err_seen), 32'h0);
`endif
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(if1.o_rd_valid), 32'h0);
            chk("idle_data", 32'(if1.o_rd_data), 32'h0);
            chk("idle_pending", 32'(if1.o_pending), 32'h0);
            chk("idle_busy", 32'(if1.o_busy), 32'h0);
        end

        // Single read, READ_LATENCY=2: bank2=A5, valid exactly at cycle 3
        bank_data = 32'h43A52110;
        rd_en = 1'b1; sel = 2'd2;
        tick();
        rd_en = 1'b0;
        chk("single_c1_pending", 32'(if2.o_pending), 32'd1);
        chk("single_c1_valid", 32'(if2.o_rd_valid), 32'h0);
        tick();
        chk("single_c2_pending", 32'(if2.o_pending), 32'd1);
        chk("single_c2_busy", 32'(if2.o_busy), 32'h1);
        chk("single_c2_valid", 32'(if2.o_rd_valid), 32'h0);
        tick();
        chk("single_c3_valid", 32'(if2.o_rd_valid), 32'h1);
        chk("single_c3_data", 32'(if2.o_rd_data), 32'hA5);
        chk("single_c3_pending", 32'(if2.o_pending), 32'd0);
        chk("single_c3_busy", 32'(if2.o_busy), 32'h0);
        tick();
        chk("single_c4_valid", 32'(if2.o_rd_valid), 32'h0);
        chk("single_c4_hold", 32'(if2.o_rd_data), 32'hA5);
        idle(6);

        // Back-to-back, READ_LATENCY=3: sel 3,0,1,2 -> 43,10,21,32 in cycles 4..7
        bank_data = 32'h43322110;
        for (int c = 0; c < 9; c++) begin
            chk("b2b_valid", 32'(if3.o_rd_valid), 32'(b2b_v[c]));
            chk("b2b_pending", 32'(if3.o_pending), 32'(b2b_p[c]));
            if (c >= 4) chk("b2b_data", 32'(if3.o_rd_data), 32'(b2b_d[c]));
            rd_en = (c < 4);
            sel   = b2b_sel[c][1:0];
            tick();
        end
        idle(6);

        // Flush, READ_LATENCY=3: requests at cycles 0,1; flush+request at cycle 2
        rd_en = 1'b1; sel = 2'd0;
        tick();
        sel = 2'd1;
        tick();
        chk("flush_c2_pending", 32'(if3.o_pending), 32'd2);
        flush = 1'b1; rd_en = 1'b1; sel = 2'd2;
        tick();
        flush = 1'b0; rd_en = 1'b0;
        for (int c = 3; c < 9; c++) begin
            chk("flush_valid", 32'(if3.o_rd_valid), 32'h0);
            chk("flush_pending", 32'(if3.o_pending), 32'd0);
            chk("flush_data_hold", 32'(if3.o_rd_data), 32'h32);
            tick();
        end
        idle(4);

        // Out-of-range select on NUM_BANKS=3, READ_LATENCY=1, then in-range sel 2
        rd_en = 1'b1; sel = 2'd3;
        tick();
        sel = 2'd2;
        chk("oor_c1_valid", 32'(if5.o_rd_valid), 32'h0);
        chk("oor_c1_data", 32'(if5.o_rd_data), 32'h10);
        tick();
        rd_en = 1'b0;
        chk("oor_c2_valid", 32'(if5.o_rd_valid), 32'h1);
        chk("oor_c2_data", 32'(if5.o_rd_data), 32'h0);
`ifdef BANK_RD_MUX_ERR_EN
        chk("oor_c2_sel_err", 32'(if5.o_sel_err), 32'h1);
        chk("oor_c2_err_seen", 32'(if5.o_err_seen), 32'h1);
`endif
        tick();
        chk("oor_c3_valid", 32'(if5.o_rd_valid), 32'h1);
        chk("oor_c3_data", 32'(if5.o_rd_data), 32'h32);
`ifdef BANK_RD_MUX_ERR_EN
        chk("oor_c3_sel_err", 32'(if5.o_sel_err), 32'h0);
        chk("oor_c3_err_seen", 32'(if5.o_err_seen), 32'h1);
`endif
        tick();
        chk("oor_c4_valid", 32'(if5.o_rd_valid), 32'h0);
        chk("oor_c4_hold", 32'(if5.o_rd_data), 32'h32);
        idle(6);

        // Async reset mid-flight, READ_LATENCY=4
        chk("arst_pre_data", 32'(if4.o_rd_data), 32'h32);
        rd_en = 1'b1; sel = 2'd1;
        tick();
        rd_en = 1'b0;
        chk("arst_c1_pending", 32'(if4.o_pending), 32'd1);
        tick();
        chk("arst_c2_pending", 32'(if4.o_pending), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if4.o_rd_valid), 32'h0);
        chk("arst_data", 32'(if4.o_rd_data), 32'h0);
        chk("arst_pending", 32'(if4.o_pending), 32'd0);
        chk("arst_busy", 32'(if4.o_busy), 32'h0);
`ifdef BANK_RD_MUX_ERR_EN
        chk("arst_err_seen", 32'(if5.o_err_seen), 32'h0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("arst_post_valid", 32'(if4.o_rd_valid), 32'h0);
            chk("arst_post_pending", 32'(if4.o_pending), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bank_rd_mux.md
Name: bank_rd_mux

Overview:
- Parametrised, latency-aware read-return multiplexer for the multi-bank memory.
- Tracks each read request's bank select and valid through a READ_LATENCY-deep pipeline.
- When the selected bank's data arrives, steers it from NUM_BANKS bank outputs onto one registered read channel.
- Supersedes the fixed 4-bank combinational mux. Sits between the bank array and the top-level read port.

Parameters:
- DATA_WIDTH, 8, width of each bank's read data and of o_rd_data.
- NUM_BANKS, 4, number of banks (2..16; need not be a power of two).
- SEL_WIDTH, 2, width of i_bank_sel; must satisfy 2**SEL_WIDTH >= NUM_BANKS.
- READ_LATENCY, 1, cycles from request sample edge to bank data valid (1..8).
- CNT_WIDTH, 4, width of o_pending; must hold READ_LATENCY+1.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rd_en  input  1  read request strobe, one request per cycle.
- i_bank_sel  input  SEL_WIDTH  bank addressed by the request (upper address bits).
- i_flush  input  1  synchronous discard of all in-flight requests.
- i_bank_data  input  NUM_BANKS*DATA_WIDTH  bank k read data at [k*DATA_WIDTH +: DATA_WIDTH].
- o_rd_data  output  DATA_WIDTH  registered read data.
- o_rd_valid  output  1  one-cycle pulse qualifying o_rd_data.
- o_pending  output  CNT_WIDTH  requests in flight, not yet returned.
- o_busy  output  1  high when o_pending != 0.

Behaviour:
- Reset (async, i_rst_n=0): pipeline valids=0, sels=0, o_rd_data=0, o_rd_valid=0, o_pending=0, o_busy=0.
- Reset mid-operation: all in-flight requests are lost; none return after reset release.
- Request capture: a request is captured at edge E0 when i_rd_en=1 and i_flush=0. Stage 0 of the pipeline loads {valid=1, sel=i_bank_sel}.
- Pipeline: stage n shifts to stage n+1 every edge with no stall. Stage READ_LATENCY-1 (the tail) is valid in the cycle after edge E_{READ_LATENCY-1}. i_bank_data is sampled at edge E_READ_LATENCY.
- Output: at E_READ_LATENCY, if the tail is valid, o_rd_data <= bank[tail sel] and o_rd_valid <= 1.
- Latency: o_rd_valid is high in the cycle after E_READ_LATENCY, i.e. READ_LATENCY+1 cycles after the request cycle.
- Throughput: back-to-back requests, one per cycle, return in order with no bubbles.
- Idle: when the tail is invalid, o_rd_valid <= 0 and o_rd_data holds its last value.
- Out-of-range select (sel >= NUM_BANKS): o_rd_data <= 0 and o_rd_valid <= 1; the return slot is still consumed.
- o_pending update per edge: +1 on capture, -1 when the tail is valid and not flushed, net 0 when both occur. It never exceeds READ_LATENCY and never underflows.
- o_busy: combinational from o_pending.
- Flush (i_flush=1 at an edge):
  - all pipeline valids cleared, including the tail;
  - a same-cycle i_rd_en is dropped (flush wins);
  - o_rd_valid <= 0 and o_pending <= 0;
  - o_rd_data unchanged.
- Select width: any i_bank_sel value is legal input; no X propagation from unused select codes.

Optional Feature:
- Macro: BANK_RD_MUX_ERR_EN.
- Defined:
  - adds output port o_sel_err (1 bit, reset 0);
  - o_sel_err pulses high together with o_rd_valid for an out-of-range select;
  - adds sticky output o_err_seen (1 bit, reset 0), set by any o_sel_err and cleared only by reset.
- Undefined: neither port exists; out-of-range selects return zero data silently.

Test Plan:
- Reset and idle, READ_LATENCY=1: hold reset 3 cycles, release, no requests for 10 cycles -> o_rd_data=0, o_rd_valid=0, o_pending=0, o_busy=0 throughout.
- Single read, READ_LATENCY=2, NUM_BANKS=4: bank2 data=8'hA5, request sel=2 at cycle 0 -> o_rd_valid=1 with o_rd_data=8'hA5 exactly at cycle 3. o_pending is 1 in cycles 1..2 and 0 from cycle 3.
- Back-to-back, READ_LATENCY=3: banks hold 8'h10/8'h21/8'h32/8'h43; requests sel=3,0,1,2 in cycles 0..3 -> o_rd_valid high cycles 4..7 with 8'h43,8'h10,8'h21,8'h32. o_pending peaks at 3.
- Flush, READ_LATENCY=3: requests at cycles 0,1; i_flush plus a request at cycle 2 -> no o_rd_valid in cycles 3..8. o_pending=0 from cycle 3. o_rd_data keeps its prior value.
- Out-of-range, NUM_BANKS=3, SEL_WIDTH=2, with BANK_RD_MUX_ERR_EN: request sel=3 -> o_rd_valid=1, o_rd_data=0, o_sel_err=1 for one cycle, o_err_seen=1 until reset.
- Async reset mid-flight, READ_LATENCY=4: request at cycle 0, assert i_rst_n=0 at mid-cycle 2 -> outputs clear immediately. After release, no o_rd_valid appears.
